// File: rtl/bp_fe_lce_responder.sv
// bp_fe_lce_responder: minimal CCE-side endpoint for a single I-cache LCE.
// Performs the boot-time sync handshake. It then services one cached or
// uncached fetch miss at a time: the miss is forwarded to memory as a read,
// and the returned data goes back to the LCE as a fill command.
//
// Message layouts (packed, MSB first):
//   lce_req  : {src_id, write, uncached, non_exclusive, lru_way, addr}
//   lce_resp : {src_id, msg_type[1:0], addr}
//   lce_cmd  : {dst_id, src_id, msg_type[2:0], way, state[1:0], addr, data}
//   mem msg  : {msg_type[1:0], size[2:0] (log2 bytes), addr, data}
module bp_fe_lce_responder #(
    parameter int unsigned cce_id_width_p     = 2,
    parameter int unsigned lce_id_width_p     = 2,
    parameter int unsigned paddr_width_p      = 32,
    parameter int unsigned lce_assoc_p        = 8,
    parameter int unsigned cce_block_width_p  = 512,
    parameter int unsigned sync_ack_timeout_p = 1024,
    localparam int unsigned way_width_lp          = $clog2(lce_assoc_p),
    localparam int unsigned lce_cce_req_width_lp  = lce_id_width_p + 3 + way_width_lp + paddr_width_p,
    localparam int unsigned lce_cce_resp_width_lp = lce_id_width_p + 2 + paddr_width_p,
    localparam int unsigned lce_cmd_width_lp      = lce_id_width_p + cce_id_width_p + 3 + way_width_lp
                                                    + 2 + paddr_width_p + cce_block_width_p,
    localparam int unsigned cce_mem_msg_width_lp  = 2 + 3 + paddr_width_p + cce_block_width_p
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [cce_id_width_p-1:0]        cce_id_i,
    input  logic [lce_id_width_p-1:0]        lce_id_i,
    input  logic [lce_cce_req_width_lp-1:0]  lce_req_i,
    input  logic                             lce_req_v_i,
    output logic                             lce_req_yumi_o,
    input  logic [lce_cce_resp_width_lp-1:0] lce_resp_i,
    input  logic                             lce_resp_v_i,
    output logic                             lce_resp_yumi_o,
    output logic [lce_cmd_width_lp-1:0]      lce_cmd_o,
    output logic                             lce_cmd_v_o,
    input  logic                             lce_cmd_ready_i,
    output logic [cce_mem_msg_width_lp-1:0]  mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_ready_i,
    input  logic [cce_mem_msg_width_lp-1:0]  mem_resp_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_yumi_o,
    output logic                             sync_done_o,
    output logic                             error_o
);

    localparam int unsigned dword_width_lp  = 64;
    localparam int unsigned block_bytes_lp  = cce_block_width_p / 8;
    localparam int unsigned cnt_width_lp    = $clog2(sync_ack_timeout_p);
    localparam logic [cnt_width_lp-1:0]  cnt_max_lp    = cnt_width_lp'(sync_ack_timeout_p - 1);
    localparam logic [paddr_width_p-1:0] block_mask_lp = ~paddr_width_p'(block_bytes_lp - 1);
    localparam logic [2:0] size_block_lp = 3'($clog2(block_bytes_lp));
    localparam logic [2:0] size_dword_lp = 3'($clog2(dword_width_lp / 8));

    typedef enum logic [1:0] {
        e_lce_cce_sync_ack = 2'd0,
        e_lce_cce_inv_ack  = 2'd1,
        e_lce_cce_coh_ack  = 2'd2,
        e_lce_cce_resp_wb  = 2'd3
    } lce_cce_resp_type_e;

    typedef enum logic [2:0] {
        e_lce_cmd_sync    = 3'd0,
        e_lce_cmd_data    = 3'd1,
        e_lce_cmd_uc_data = 3'd2
    } lce_cmd_type_e;

    typedef enum logic [1:0] {
        e_COH_I = 2'd0,
        e_COH_S = 2'd1,
        e_COH_E = 2'd2,
        e_COH_M = 2'd3
    } coh_state_e;

    typedef enum logic [1:0] {
        e_mem_rd    = 2'd0,
        e_mem_uc_rd = 2'd1
    } mem_type_e;

    typedef struct packed {
        logic [lce_id_width_p-1:0] src_id;
        logic                      write;
        logic                      uncached;
        logic                      non_exclusive;
        logic [way_width_lp-1:0]   lru_way;
        logic [paddr_width_p-1:0]  addr;
    } lce_req_s;

    typedef struct packed {
        logic [lce_id_width_p-1:0] src_id;
        logic [1:0]                msg_type;
        logic [paddr_width_p-1:0]  addr;
    } lce_resp_s;

    typedef struct packed {
        logic [lce_id_width_p-1:0]    dst_id;
        logic [cce_id_width_p-1:0]    src_id;
        logic [2:0]                   msg_type;
        logic [way_width_lp-1:0]      way;
        logic [1:0]                   state;
        logic [paddr_width_p-1:0]     addr;
        logic [cce_block_width_p-1:0] data;
    } lce_cmd_s;

    typedef struct packed {
        logic [1:0]                   msg_type;
        logic [2:0]                   size;
        logic [paddr_width_p-1:0]     addr;
        logic [cce_block_width_p-1:0] data;
    } mem_msg_s;

    typedef enum logic [3:0] {
        st_reset,
        st_sync_cmd,
        st_sync_ack,
        st_ready,
        st_mem_cmd,
        st_mem_resp,
        st_data_cmd,
        st_uc_cmd,
        st_ack_wait
    } state_e;

    state_e state, state_n;

    lce_req_s  req;
    lce_resp_s resp;
    mem_msg_s  mem_resp;
    lce_cmd_s  cmd;
    mem_msg_s  mem_cmd;

    assign req      = lce_req_i;
    assign resp     = lce_resp_i;
    assign mem_resp = mem_resp_i;

    logic [cnt_width_lp-1:0]      sync_cnt;
    logic                         sync_done_r;
    logic                         error_r;
    logic [paddr_width_p-1:0]     addr_r;
    logic [way_width_lp-1:0]      way_r;
    logic                         non_exclusive_r;
    logic                         uncached_r;
    logic [cce_block_width_p-1:0] data_r;

    logic set_error;
    logic set_sync_done;
    logic latch_req;
    logic latch_data;

    logic [paddr_width_p-1:0] block_addr;
    assign block_addr = addr_r & block_mask_lp;

    // Next-state and handshake/payload decode. Nothing is consumed or issued
    // while reset is held, so a transaction in flight is abandoned cleanly.
    always_comb begin
        state_n         = state;
        lce_req_yumi_o  = 1'b0;
        lce_resp_yumi_o = 1'b0;
        lce_cmd_v_o     = 1'b0;
        cmd             = '0;
        mem_cmd_v_o     = 1'b0;
        mem_cmd         = '0;
        mem_resp_yumi_o = 1'b0;
        set_error       = 1'b0;
        set_sync_done   = 1'b0;
        latch_req       = 1'b0;
        latch_data      = 1'b0;

        if (!reset_i) begin
            case (state)
                st_reset: begin
                    state_n = st_sync_cmd;
                end

                st_sync_cmd: begin
                    lce_cmd_v_o  = 1'b1;
                    cmd.dst_id   = lce_id_i;
                    cmd.src_id   = cce_id_i;
                    cmd.msg_type = e_lce_cmd_sync;
                    if (lce_cmd_ready_i) begin
                        state_n = st_sync_ack;
                    end
                end

                st_sync_ack: begin
                    if (lce_resp_v_i) begin
                        lce_resp_yumi_o = 1'b1;
                        if (resp.msg_type == e_lce_cce_sync_ack) begin
                            set_sync_done = 1'b1;
                            state_n       = st_ready;
                        end else begin
                            set_error = 1'b1;
                        end
                    end
                    if (sync_cnt == cnt_max_lp) begin
                        set_error = 1'b1;
                    end
                end

                st_ready: begin
                    if (lce_req_v_i) begin
                        lce_req_yumi_o = 1'b1;
                        if (req.write) begin
                            set_error = 1'b1;
                        end else begin
                            latch_req = 1'b1;
                            state_n   = st_mem_cmd;
                        end
                    end
                    if (lce_resp_v_i) begin
                        lce_resp_yumi_o = 1'b1;
                        set_error       = 1'b1;
                    end
                end

                st_mem_cmd: begin
                    mem_cmd_v_o = 1'b1;
                    if (uncached_r) begin
                        mem_cmd.msg_type = e_mem_uc_rd;
                        mem_cmd.size     = size_dword_lp;
                        mem_cmd.addr     = addr_r;
                    end else begin
                        mem_cmd.msg_type = e_mem_rd;
                        mem_cmd.size     = size_block_lp;
                        mem_cmd.addr     = block_addr;
                    end
                    if (mem_cmd_ready_i) begin
                        state_n = st_mem_resp;
                    end
                end

                st_mem_resp: begin
                    if (mem_resp_v_i) begin
                        mem_resp_yumi_o = 1'b1;
                        latch_data      = 1'b1;
                        state_n         = uncached_r ? st_uc_cmd : st_data_cmd;
                    end
                end

                st_data_cmd: begin
                    lce_cmd_v_o  = 1'b1;
                    cmd.dst_id   = lce_id_i;
                    cmd.src_id   = cce_id_i;
                    cmd.msg_type = e_lce_cmd_data;
                    cmd.way      = way_r;
                    cmd.state    = e_COH_S;
                    cmd.addr     = block_addr;
                    cmd.data     = data_r;
                    if (lce_cmd_ready_i) begin
                        state_n = st_ack_wait;
                    end
                end

                st_uc_cmd: begin
                    lce_cmd_v_o  = 1'b1;
                    cmd.dst_id   = lce_id_i;
                    cmd.src_id   = cce_id_i;
                    cmd.msg_type = e_lce_cmd_uc_data;
                    cmd.way      = way_r;
                    cmd.state    = e_COH_I;
                    cmd.addr     = addr_r;
                    cmd.data     = cce_block_width_p'(data_r[dword_width_lp-1:0]);
                    if (lce_cmd_ready_i) begin
                        state_n = st_ready;
                    end
                end

                st_ack_wait: begin
                    if (lce_resp_v_i) begin
                        lce_resp_yumi_o = 1'b1;
                        if ((resp.msg_type != e_lce_cce_coh_ack) || (resp.addr != block_addr)) begin
                            set_error = 1'b1;
                        end
                        state_n = st_ready;
                    end
                end

                default: begin
                    state_n = st_reset;
                end
            endcase
        end
    end

    assign lce_cmd_o = cmd;
    assign mem_cmd_o = mem_cmd;

    // State register, sync-ack timeout counter and sticky status flags.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= st_reset;
            sync_cnt    <= '0;
            sync_done_r <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state <= state_n;
            if (state != st_sync_ack) begin
                sync_cnt <= '0;
            end else if (sync_cnt != cnt_max_lp) begin
                sync_cnt <= sync_cnt + cnt_width_lp'(1);
            end
            if (set_sync_done) begin
                sync_done_r <= 1'b1;
            end
            if (set_error) begin
                error_r <= 1'b1;
            end
        end
    end

    // Latches for the single outstanding request and its returned block.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_r          <= '0;
            way_r           <= '0;
            non_exclusive_r <= 1'b0;
            uncached_r      <= 1'b0;
            data_r          <= '0;
        end else begin
            if (latch_req) begin
                addr_r          <= req.addr;
                way_r           <= req.lru_way;
                non_exclusive_r <= req.non_exclusive;
                uncached_r      <= req.uncached;
            end
            if (latch_data) begin
                data_r <= mem_resp.data;
            end
        end
    end

    assign sync_done_o = sync_done_r;
    assign error_o     = error_r;

    // Fields carried by the message formats but not needed by this endpoint.
    logic unused_fields;
    assign unused_fields = ^{req.src_id, resp.src_id, mem_resp.msg_type,
                             mem_resp.size, mem_resp.addr, non_exclusive_r};

endmodule
